// File: rtl/swerv_types_pkg.sv
// Shared LSU pipeline types: per-stage packet state and pipeline depth.
package swerv_types_pkg;

    // One LSU pipeline stage: valid plus the type bits that ride along with it.
    typedef struct packed {
        logic valid;
        logic store;
        logic dma;
    } lsu_stage_t;

    localparam int LSU_NSTAGES = 5;

    localparam lsu_stage_t LSU_STAGE_BUBBLE = '{valid: 1'b0, store: 1'b0, dma: 1'b0};

    // Type bits are meaningless without valid; force them low so the
    // clock-gating consumer never sees a store/dma bit on an empty stage.
    function automatic lsu_stage_t lsu_stage_clean(input lsu_stage_t s);
        lsu_stage_t r;
        r.valid = s.valid;
        r.store = s.valid & s.store;
        r.dma   = s.valid & s.dma;
        return r;
    endfunction

endpackage

// File: rtl/lsu_pkt_stage.sv
// One LSU pipeline stage register with kill (highest priority), hold and load.
module lsu_pkt_stage
    import swerv_types_pkg::*;
(
    input  logic       clk,
    input  logic       rst_l,
    input  logic       hold_i,
    input  logic       kill_i,
    input  lsu_stage_t d_i,
    output lsu_stage_t nxt_o,
    output lsu_stage_t q_o
);

    lsu_stage_t stage_q;
    lsu_stage_t stage_d;

    // Next-state selection; kill beats hold so a flush empties frozen stages too.
    always_comb begin
        stage_d = lsu_stage_clean(d_i);
        if (kill_i) begin
            stage_d = LSU_STAGE_BUBBLE;
        end else if (hold_i) begin
            stage_d = stage_q;
        end
    end

    // Stage state register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            stage_q <= LSU_STAGE_BUBBLE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign nxt_o = stage_d;
    assign q_o   = stage_q;

endmodule

// File: rtl/lsu_pkt_pipe.sv
// LSU packet valid/type pipeline dc1..dc5 with entry arbitration, freeze/flush
// handling, occupancy/idle status and a freeze-duration watchdog.
module lsu_pkt_pipe
    import swerv_types_pkg::*;
#(
    parameter int FRZ_CNT_W = 8,
    parameter int FRZ_MAX   = 200
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 dec_lsu_valid_d,
    input  logic                 dec_lsu_store_d,
    input  logic                 dma_dccm_req,
    input  logic                 dma_mem_write,
    input  logic                 lsu_freeze_dc3,
    input  logic                 flush_younger,
    output logic                 dma_dccm_grant,
    output logic                 lsu_p_valid,
    output logic                 lsu_p_store,
    output logic                 pkt_dc1_valid,
    output logic                 pkt_dc1_store,
    output logic                 pkt_dc1_dma,
    output logic                 pkt_dc2_valid,
    output logic                 pkt_dc2_store,
    output logic                 pkt_dc2_dma,
    output logic                 pkt_dc3_valid,
    output logic                 pkt_dc3_store,
    output logic                 pkt_dc3_dma,
    output logic                 pkt_dc4_valid,
    output logic                 pkt_dc4_store,
    output logic                 pkt_dc4_dma,
    output logic                 pkt_dc5_valid,
    output logic                 pkt_dc5_store,
    output logic                 pkt_dc5_dma,
    output logic [2:0]           lsu_pipe_occ,
    output logic                 lsu_pipe_idle,
    output logic                 frz_timeout
);

    localparam logic [FRZ_CNT_W-1:0] FRZ_MAX_C = FRZ_CNT_W'(FRZ_MAX);

    logic                          freeze;
    lsu_stage_t                    entry;
    lsu_stage_t [LSU_NSTAGES-1:0]  st_d;
    lsu_stage_t [LSU_NSTAGES-1:0]  st_nxt;
    lsu_stage_t [LSU_NSTAGES-1:0]  st_q;
    logic       [LSU_NSTAGES-1:0]  st_hold;
    logic       [LSU_NSTAGES-1:0]  st_kill;
    logic       [2:0]              occ_d, occ_q;
    logic       [FRZ_CNT_W-1:0]    frz_cnt_d, frz_cnt_q;
    logic                          frz_tmo_d, frz_tmo_q;

    assign freeze = lsu_freeze_dc3;

    // Entry arbitration: decode wins; nothing enters while frozen.
    always_comb begin
        lsu_p_valid    = ~freeze & (dec_lsu_valid_d | dma_dccm_req);
        dma_dccm_grant = ~freeze & ~dec_lsu_valid_d & dma_dccm_req;
        entry.valid    = lsu_p_valid;
        entry.store    = dec_lsu_valid_d ? dec_lsu_store_d : dma_mem_write;
        entry.dma      = ~dec_lsu_valid_d & dma_dccm_req;
        lsu_p_store    = lsu_p_valid & entry.store;
    end

    // Stage wiring: dc1..dc3 hold on freeze, dc4 takes a bubble so the frozen
    // dc3 op is not duplicated, flush kills dc1..dc4 while dc5 still retires dc4.
    always_comb begin
        st_d[0] = entry;
        st_d[1] = st_q[0];
        st_d[2] = st_q[1];
        st_d[3] = freeze ? LSU_STAGE_BUBBLE : st_q[2];
        st_d[4] = st_q[3];
        st_hold = {2'b00, {3{freeze}}};
        st_kill = {1'b0, {4{flush_younger}}};
    end

    for (genvar i = 0; i < LSU_NSTAGES; i++) begin : g_stage
        lsu_pkt_stage u_stage (
            .clk    (clk),
            .rst_l  (rst_l),
            .hold_i (st_hold[i]),
            .kill_i (st_kill[i]),
            .d_i    (st_d[i]),
            .nxt_o  (st_nxt[i]),
            .q_o    (st_q[i])
        );
    end

    // Occupancy is the popcount of next-state valids, so the register tracks the stages.
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < LSU_NSTAGES; i++) begin
            occ_d = occ_d + {2'b00, st_nxt[i].valid};
        end
    end

    // Freeze watchdog: count consecutive frozen cycles, saturate, sticky timeout.
    always_comb begin
        frz_cnt_d = '0;
        if (freeze) begin
            frz_cnt_d = (frz_cnt_q == FRZ_MAX_C) ? frz_cnt_q : frz_cnt_q + FRZ_CNT_W'(1);
        end
        frz_tmo_d = frz_tmo_q | (frz_cnt_d == FRZ_MAX_C);
    end

    // Status registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            occ_q     <= '0;
            frz_cnt_q <= '0;
            frz_tmo_q <= 1'b0;
        end else begin
            occ_q     <= occ_d;
            frz_cnt_q <= frz_cnt_d;
            frz_tmo_q <= frz_tmo_d;
        end
    end

    assign lsu_pipe_occ  = occ_q;
    assign lsu_pipe_idle = (occ_q == 3'd0) & ~lsu_p_valid;
    assign frz_timeout   = frz_tmo_q;

    assign pkt_dc1_valid = st_q[0].valid;
    assign pkt_dc1_store = st_q[0].store;
    assign pkt_dc1_dma   = st_q[0].dma;
    assign pkt_dc2_valid = st_q[1].valid;
    assign pkt_dc2_store = st_q[1].store;
    assign pkt_dc2_dma   = st_q[1].dma;
    assign pkt_dc3_valid = st_q[2].valid;
    assign pkt_dc3_store = st_q[2].store;
    assign pkt_dc3_dma   = st_q[2].dma;
    assign pkt_dc4_valid = st_q[3].valid;
    assign pkt_dc4_store = st_q[3].store;
    assign pkt_dc4_dma   = st_q[3].dma;
    assign pkt_dc5_valid = st_q[4].valid;
    assign pkt_dc5_store = st_q[4].store;
    assign pkt_dc5_dma   = st_q[4].dma;

endmodule

// File: tb/tb_lsu_pkt_pipe.sv
// Scoreboard bench for lsu_pkt_pipe: stimulus pushes expected observations
// from an array-based pipeline model, a monitor pops and compares each cycle.
module tb_lsu_pkt_pipe;

    localparam int FRZ_MAX = 200;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    logic dec_lsu_valid_d = 1'b0, dec_lsu_store_d = 1'b0;
    logic dma_dccm_req = 1'b0, dma_mem_write = 1'b0;
    logic lsu_freeze_dc3 = 1'b0, flush_younger = 1'b0;
    logic dma_dccm_grant, lsu_p_valid, lsu_p_store;
    logic pkt_dc1_valid, pkt_dc1_store, pkt_dc1_dma;
    logic pkt_dc2_valid, pkt_dc2_store, pkt_dc2_dma;
    logic pkt_dc3_valid, pkt_dc3_store, pkt_dc3_dma;
    logic pkt_dc4_valid, pkt_dc4_store, pkt_dc4_dma;
    logic pkt_dc5_valid, pkt_dc5_store, pkt_dc5_dma;
    logic [2:0] lsu_pipe_occ;
    logic lsu_pipe_idle, frz_timeout;

    always #5 clk = ~clk;

    lsu_pkt_pipe #(.FRZ_CNT_W(8), .FRZ_MAX(FRZ_MAX)) dut (
        .clk(clk), .rst_l(rst_l),
        .dec_lsu_valid_d(dec_lsu_valid_d), .dec_lsu_store_d(dec_lsu_store_d),
        .dma_dccm_req(dma_dccm_req), .dma_mem_write(dma_mem_write),
        .lsu_freeze_dc3(lsu_freeze_dc3), .flush_younger(flush_younger),
        .dma_dccm_grant(dma_dccm_grant), .lsu_p_valid(lsu_p_valid), .lsu_p_store(lsu_p_store),
        .pkt_dc1_valid(pkt_dc1_valid), .pkt_dc1_store(pkt_dc1_store), .pkt_dc1_dma(pkt_dc1_dma),
        .pkt_dc2_valid(pkt_dc2_valid), .pkt_dc2_store(pkt_dc2_store), .pkt_dc2_dma(pkt_dc2_dma),
        .pkt_dc3_valid(pkt_dc3_valid), .pkt_dc3_store(pkt_dc3_store), .pkt_dc3_dma(pkt_dc3_dma),
        .pkt_dc4_valid(pkt_dc4_valid), .pkt_dc4_store(pkt_dc4_store), .pkt_dc4_dma(pkt_dc4_dma),
        .pkt_dc5_valid(pkt_dc5_valid), .pkt_dc5_store(pkt_dc5_store), .pkt_dc5_dma(pkt_dc5_dma),
        .lsu_pipe_occ(lsu_pipe_occ), .lsu_pipe_idle(lsu_pipe_idle), .frz_timeout(frz_timeout)
    );

    typedef struct packed {
        logic       grant;
        logic       pv;
        logic       ps;
        logic       idle;
        logic [4:0] v;
        logic [4:0] s;
        logic [4:0] d;
        logic [2:0] occ;
        logic       tmo;
    } obs_t;

    typedef struct packed {
        logic v;
        logic s;
        logic d;
    } pkt_t;

    obs_t exp_q[$];
    obs_t act, e_mon;
    int   checks = 0;
    int   errors = 0;

    // Behavioural model state: the five stages as an array, freeze run length.
    pkt_t pipe [1:5];
    int   frz_run;
    bit   tmo_m;

    always_comb begin
        act.grant = dma_dccm_grant;
        act.pv    = lsu_p_valid;
        act.ps    = lsu_p_store;
        act.idle  = lsu_pipe_idle;
        act.v     = {pkt_dc5_valid, pkt_dc4_valid, pkt_dc3_valid, pkt_dc2_valid, pkt_dc1_valid};
        act.s     = {pkt_dc5_store, pkt_dc4_store, pkt_dc3_store, pkt_dc2_store, pkt_dc1_store};
        act.d     = {pkt_dc5_dma, pkt_dc4_dma, pkt_dc3_dma, pkt_dc2_dma, pkt_dc1_dma};
        act.occ   = lsu_pipe_occ;
        act.tmo   = frz_timeout;
    end

    task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, a, x, $time);
        end
    endtask

    // Monitor: every negedge with a pending expectation, compare all outputs.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e_mon = exp_q.pop_front();
                chk("entry_grant_pv_ps_idle", {12'd0, act.grant, act.pv, act.ps, act.idle},
                    {12'd0, e_mon.grant, e_mon.pv, e_mon.ps, e_mon.idle});
                chk("stage_valid", {11'd0, act.v}, {11'd0, e_mon.v});
                chk("stage_store", {11'd0, act.s}, {11'd0, e_mon.s});
                chk("stage_dma",   {11'd0, act.d}, {11'd0, e_mon.d});
                chk("occ",         {13'd0, act.occ}, {13'd0, e_mon.occ});
                chk("frz_timeout", {15'd0, act.tmo}, {15'd0, e_mon.tmo});
            end
        end
    end

    // One clock of stimulus: drive inputs, predict this cycle's outputs, advance model.
    task automatic cyc(input bit dv, input bit ds, input bit dr, input bit dw,
                       input bit frz, input bit fl, input bit rst = 1'b0);
        obs_t e;
        pkt_t ent;
        pkt_t nw [1:5];
        int   cnt;
        @(posedge clk);
        #1;
        rst_l           = !rst;
        dec_lsu_valid_d = dv;
        dec_lsu_store_d = ds;
        dma_dccm_req    = dr;
        dma_mem_write   = dw;
        lsu_freeze_dc3  = frz;
        flush_younger   = fl;
        if (rst) begin
            for (int i = 1; i <= 5; i++) pipe[i] = '0;
            frz_run = 0;
            tmo_m   = 1'b0;
        end
        cnt = 0;
        for (int i = 1; i <= 5; i++) begin
            e.v[i-1] = pipe[i].v;
            e.s[i-1] = pipe[i].s;
            e.d[i-1] = pipe[i].d;
            if (pipe[i].v) cnt++;
        end
        e.pv    = !frz && (dv || dr);
        e.grant = !frz && !dv && dr;
        e.ps    = e.pv && (dv ? ds : dw);
        e.occ   = 3'(cnt);
        e.idle  = (cnt == 0) && !e.pv;
        e.tmo   = tmo_m;
        exp_q.push_back(e);
        if (!rst) begin
            ent = '{v: e.pv, s: e.ps, d: e.pv && !dv};
            nw[5] = pipe[4];
            if (fl) begin
                for (int i = 1; i <= 4; i++) nw[i] = '0;
            end else if (frz) begin
                for (int i = 1; i <= 3; i++) nw[i] = pipe[i];
                nw[4] = '0;
            end else begin
                nw[1] = ent;
                for (int i = 2; i <= 4; i++) nw[i] = pipe[i-1];
            end
            for (int i = 1; i <= 5; i++) pipe[i] = nw[i];
            frz_run = frz ? ((frz_run < FRZ_MAX) ? frz_run + 1 : frz_run) : 0;
            if (frz_run == FRZ_MAX) tmo_m = 1'b1;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int frz_left;
        bit dma_pend, dma_wr;
        frz_left = 0;
        dma_pend = 1'b0;
        dma_wr   = 1'b0;
        for (int i = 1; i <= 5; i++) pipe[i] = '0;
        frz_run = 0;
        tmo_m   = 1'b0;

        // Reset, then a single decode store walking dc1..dc5.
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        idle_cycles(1);
        cyc(1, 1, 0, 0, 0, 0);
        idle_cycles(6);

        // Three loads back-to-back, freeze for two cycles while load#1 sits in dc3.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        idle_cycles(6);

        // Decode and DMA together: decode wins, DMA granted the next cycle.
        cyc(1, 0, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        idle_cycles(6);

        // Fill all five stages, then flush_younger: only the old dc4 survives into dc5.
        for (int i = 0; i < 5; i++) cyc(1, i[0], 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        idle_cycles(3);

        // Simultaneous freeze and flush on a partly filled pipe.
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1);
        idle_cycles(3);

        // Randomised traffic with short freeze runs and DMA that holds its request.
        for (int n = 0; n < 400; n++) begin
            bit dv, ds, fl, frz, dr;
            if (frz_left == 0 && $urandom_range(0, 9) == 0) frz_left = $urandom_range(1, 6);
            frz = (frz_left > 0);
            if (frz_left > 0) frz_left--;
            dv = ($urandom_range(0, 1) == 1);
            ds = ($urandom_range(0, 1) == 1);
            fl = ($urandom_range(0, 15) == 0);
            if (!dma_pend && $urandom_range(0, 2) == 0) begin
                dma_pend = 1'b1;
                dma_wr   = ($urandom_range(0, 1) == 1);
            end
            dr = dma_pend && !fl;
            cyc(dv, ds, dr, dma_wr, frz, fl);
            if (dr && !frz && !dv) dma_pend = 1'b0;
        end
        idle_cycles(2);

        // Long freeze: timeout must set exactly at FRZ_MAX and stay set afterwards.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < FRZ_MAX + 5; i++) cyc(0, 0, 0, 0, 1, 0);
        idle_cycles(4);

        // Occupancy 4 mid-freeze, then asynchronous reset clears everything at once.
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        idle_cycles(3);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
